// File: rtl/debounce_multi_if.sv
// debounce_multi_if: button-conditioner bus bundling raw inputs and conditioned outputs.
//   master : drives btn_in, observes conditioned outputs (board / test side)
//   slave  : samples btn_in, drives btn_state, btn_pressed, btn_released,
//            btn_repeat and any_pressed (conditioner side)
interface debounce_multi_if #(
  parameter int unsigned CHANNELS = 4
) ();

  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_state;
  logic [CHANNELS-1:0] btn_pressed;
  logic [CHANNELS-1:0] btn_released;
  logic [CHANNELS-1:0] btn_repeat;
  logic                any_pressed;

  modport master (
    output btn_in,
    input  btn_state,
    input  btn_pressed,
    input  btn_released,
    input  btn_repeat,
    input  any_pressed
  );

  modport slave (
    input  btn_in,
    output btn_state,
    output btn_pressed,
    output btn_released,
    output btn_repeat,
    output any_pressed
  );

endinterface

// File: rtl/debounce_multi.sv
// debounce_multi: multi-channel push-button conditioner.
// Each channel runs a two-flop synchroniser, a stability counter that accepts a
// new level after STABLE_CNT consecutive differing samples, and registered
// one-cycle press/release pulses.
// Optional feature macro: DEBOUNCE_REPEAT_EN adds a per-channel hold timer that
// issues btn_repeat pulses HOLD_CNT cycles after a press and every REPEAT_CNT
// cycles after that; without it btn_repeat is constant 0.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : debounce_multi_if.slave (btn_in in; btn_state, btn_pressed,
//          btn_released, btn_repeat, any_pressed out)
module debounce_multi #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned STABLE_CNT = 250,
  parameter bit          ACTIVE_LOW = 1'b0,
  parameter int unsigned HOLD_W     = 16,
  parameter int unsigned HOLD_CNT   = 50000,
  parameter int unsigned REPEAT_CNT = 10000
) (
  input logic              clk,
  input logic              rst,
  debounce_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [CHANNELS-1:0] sync2_q, sync2_d;
  logic [CHANNELS-1:0] state_q, state_d;
  logic [CHANNELS-1:0] pressed_q, pressed_d;
  logic [CHANNELS-1:0] released_q, released_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  // Synchroniser and stability counter; a sample matching the current level clears the count
  always_comb begin
    sync1_d    = bus.btn_in ^ {CHANNELS{ACTIVE_LOW}};
    sync2_d    = sync1_q;
    state_d    = state_q;
    pressed_d  = '0;
    released_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != state_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]    = sync2_q[i];
          pressed_d[i]  = sync2_q[i];
          released_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      state_q    <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.btn_state    = state_q;
  assign bus.btn_pressed  = pressed_q;
  assign bus.btn_released = released_q;
  assign bus.any_pressed  = |pressed_q;

`ifdef DEBOUNCE_REPEAT_EN
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CNT - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CNT - 1);

  logic [HOLD_W-1:0]   hold_q [CHANNELS];
  logic [HOLD_W-1:0]   hold_d [CHANNELS];
  logic [CHANNELS-1:0] rep_phase_q, rep_phase_d;
  logic [CHANNELS-1:0] repeat_q, repeat_d;

  // Hold timer: first period is HOLD_CNT, then REPEAT_CNT; release wins over a due repeat
  always_comb begin
    rep_phase_d = rep_phase_q;
    repeat_d    = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      hold_d[i] = hold_q[i];
      if (pressed_d[i] || released_d[i] || !state_q[i]) begin
        hold_d[i]      = '0;
        rep_phase_d[i] = 1'b0;
      end else if (!rep_phase_q[i] && (hold_q[i] == HOLD_LAST)) begin
        repeat_d[i]    = 1'b1;
        hold_d[i]      = '0;
        rep_phase_d[i] = 1'b1;
      end else if (rep_phase_q[i] && (hold_q[i] == REP_LAST)) begin
        repeat_d[i] = 1'b1;
        hold_d[i]   = '0;
      end else begin
        hold_d[i] = hold_q[i] + HOLD_W'(1);
      end
    end
  end

  // Hold timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_phase_q <= '0;
      repeat_q    <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      rep_phase_q <= rep_phase_d;
      repeat_q    <= repeat_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        hold_q[i] <= hold_d[i];
      end
    end
  end

  assign bus.btn_repeat = repeat_q;
`else
  // Repeat logic compiled out; hold parameters stay referenced so the build is parameter-clean
  localparam bit REP_CFG_OK = (HOLD_W > 0) && (REPEAT_CNT >= 1) && (REPEAT_CNT <= HOLD_CNT);

  assign bus.btn_repeat = {CHANNELS{1'b0 & REP_CFG_OK}};
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed vector table plus randomized stimulus for debounce_multi.
// Two instances run side by side (ACTIVE_LOW=0 and ACTIVE_LOW=1, the latter fed the
// inverted press pattern) and are checked against one reference model.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int SC = 4;
  localparam int CW = 8;
  localparam int HW = 8;
  localparam int HC = 10;
  localparam int RC = 3;

`ifdef DEBOUNCE_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  localparam logic [CH-1:0] RP2 = REP_ON ? 4'h4 : 4'h0;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  debounce_multi_if #(.CHANNELS(CH)) bus_hi ();
  debounce_multi_if #(.CHANNELS(CH)) bus_lo ();

  debounce_multi #(
    .CHANNELS(CH), .CNT_W(CW), .STABLE_CNT(SC), .ACTIVE_LOW(1'b0),
    .HOLD_W(HW), .HOLD_CNT(HC), .REPEAT_CNT(RC)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .bus(bus_hi)
  );

  debounce_multi #(
    .CHANNELS(CH), .CNT_W(CW), .STABLE_CNT(SC), .ACTIVE_LOW(1'b1),
    .HOLD_W(HW), .HOLD_CNT(HC), .REPEAT_CNT(RC)
  ) u_dut_lo (
    .clk(clk), .rst(rst), .bus(bus_lo)
  );

  typedef struct {
    logic          rst;
    logic [CH-1:0] press;
    logic [CH-1:0] st;
    logic [CH-1:0] pr;
    logic [CH-1:0] rl;
    logic [CH-1:0] rp;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic          cur_rst;
  logic [CH-1:0] cur_press;

  // Reference model: hist[k] holds the logical sample taken k+1 edges ago
  logic [CH-1:0] hist [SC+1];
  logic [CH-1:0] m_st, m_pr, m_rl, m_rp;
  int            m_since [CH];

  function automatic void add(input logic r, input logic [CH-1:0] p, input logic [CH-1:0] s,
                              input logic [CH-1:0] pr, input logic [CH-1:0] rl,
                              input logic [CH-1:0] rp);
    vec_t v;
    v.rst = r; v.press = p; v.st = s; v.pr = pr; v.rl = rl; v.rp = rp;
    tbl.push_back(v);
  endfunction

  function automatic logic [4*CH:0] pack(input logic a, input logic [CH-1:0] rp,
                                         input logic [CH-1:0] rl, input logic [CH-1:0] pr,
                                         input logic [CH-1:0] st);
    return {a, rp, rl, pr, st};
  endfunction

  // A level is accepted once the last SC synchronised samples all differ from it
  task automatic model_step();
    logic all_diff;
    m_pr = '0;
    m_rl = '0;
    m_rp = '0;
    if (cur_rst) begin
      for (int k = 0; k <= SC; k++) hist[k] = '0;
      m_st = '0;
      for (int c = 0; c < CH; c++) m_since[c] = 0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= SC; k++) if (hist[k][c] == m_st[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_st[c] = ~m_st[c];
          if (m_st[c]) begin
            m_pr[c]    = 1'b1;
            m_since[c] = 0;
          end else begin
            m_rl[c] = 1'b1;
          end
        end else if (m_st[c]) begin
          m_since[c] = m_since[c] + 1;
          if (REP_ON && (m_since[c] >= HC) && (((m_since[c] - HC) % RC) == 0)) m_rp[c] = 1'b1;
        end
      end
      for (int k = SC; k >= 1; k--) hist[k] = hist[k-1];
      hist[0] = cur_press;
    end
  endtask

  task automatic drive();
    rst           = cur_rst;
    bus_hi.btn_in = cur_press;
    bus_lo.btn_in = ~cur_press;
  endtask

  task automatic check(input string name, input logic [4*CH:0] got, input logic [4*CH:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d {any,rep,rel,prs,state} got=%b exp=%b", name, cyc, got, exp);
    end
  endtask

  function automatic logic [4*CH:0] got_hi();
    return pack(bus_hi.any_pressed, bus_hi.btn_repeat, bus_hi.btn_released,
                bus_hi.btn_pressed, bus_hi.btn_state);
  endfunction

  function automatic logic [4*CH:0] got_lo();
    return pack(bus_lo.any_pressed, bus_lo.btn_repeat, bus_lo.btn_released,
                bus_lo.btn_pressed, bus_lo.btn_state);
  endfunction

  // One clock: advance model on the edge, compare both instances 1 time unit later
  task automatic tick(input string tag);
    logic [4*CH:0] exp;
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    exp = pack(|m_pr, m_rp, m_rl, m_pr, m_st);
    check({tag, "_model_hi"}, got_hi(), exp);
    check({tag, "_model_lo"}, got_lo(), exp);
  endtask

  initial begin
    logic [4*CH:0] texp;
    cur_rst   = 1'b1;
    cur_press = '0;
    m_st      = '0;
    for (int k = 0; k <= SC; k++) hist[k] = '0;
    for (int c = 0; c < CH; c++) m_since[c] = 0;
    drive();

    // Reset, then ch0 press accepted on the sixth sampling edge and released
    repeat (3) add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (5) add(1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0);
    repeat (5) add(1'b0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0);
    // ch1 glitch bursts rejected, then a clean hold accepted and released
    repeat (3) begin
      repeat (3) add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
      add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end
    repeat (5) add(1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0);
    repeat (5) add(1'b0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h2, 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    // ch0 and ch3 together
    repeat (5) add(1'b0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h9, 4'h9, 4'h9, 4'h0, 4'h0);
    add(1'b0, 4'h9, 4'h9, 4'h0, 4'h0, 4'h0);
    // ch2 press interrupted by reset, then accepted six edges after reset falls
    repeat (3) add(1'b0, 4'h4, 4'h9, 4'h0, 4'h0, 4'h0);
    add(1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (5) add(1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1'b0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0);
    // ch2 held: repeats at +10, +13, +16, +19; release lands where +25 would be
    for (int k = 1; k <= 19; k++)
      add(1'b0, 4'h4, 4'h4, 4'h0, 4'h0,
          (k == 10 || k == 13 || k == 16 || k == 19) ? RP2 : 4'h0);
    for (int l = 1; l <= 5; l++)
      add(1'b0, 4'h0, 4'h4, 4'h0, 4'h0, (l == 3) ? RP2 : 4'h0);
    add(1'b0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h0);
    repeat (2) add(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      cur_rst   = tbl[i].rst;
      cur_press = tbl[i].press;
      drive();
      tick($sformatf("dir%0d", i));
      texp = pack(|tbl[i].pr, tbl[i].rp, tbl[i].rl, tbl[i].pr, tbl[i].st);
      check($sformatf("tbl%0d_hi", i), got_hi(), texp);
      check($sformatf("tbl%0d_lo", i), got_lo(), texp);
    end

    // Random bouncing near the threshold, then longer holds that reach the repeat timer
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 1500; n++) begin
        for (int c = 0; c < CH; c++)
          if ($urandom_range((ph == 0) ? 3 : 15, 0) == 0) cur_press[c] = ~cur_press[c];
        cur_rst = ($urandom_range(199, 0) == 0);
        drive();
        tick("rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
